multicycle_controller: RTL and testbench

- Moore FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, one ALU reused for PC+4, branch target and execute.
- Decodes Instruction[31:26] latched in IR.
- Drives per-state mux selects and write enables.
- Handles a memory-ready handshake, run/stop control, illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_controller_pkg.sv | 60 ++++++
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the controller state encoding, the opcode constants decoded from
// IR[31:26], and the ALUOp / ALUSrcB / PCSource encodings. The datapath
// muxes and ALU_Control import the same values so every block agrees.
package multicycle_controller_pkg;

  // Controller states, 4-bit encoding
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  // Instruction[31:26] opcodes
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALUOp: how ALU_Control should interpret the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB: second ALU operand
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource: next-PC mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that complete an instruction unconditionally (MEM_WRITE also
  // retires, but only once memory accepts the write).
  function automatic logic is_final_state(input state_t s);
    logic r;
    case (s)
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Inputs : clk, rst (async, active-high), run, Opcode (IR[31:26]),
//          mem_ready (memory completes the current access this cycle).
// Outputs: datapath mux selects / write enables (PCWrite .. PCSource),
//          halted (illegal opcode trapped), busy (not IDLE/TRAP),
//          instr_count (retired instructions, wraps).
// Control outputs decode from the state register only, so an asserted rst
// clears them immediately. The one exception is FETCH, where IRWrite and
// PCWrite follow mem_ready so IR and PC load exactly on the completing cycle.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_WIDTH  = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [OP_WIDTH-1:0]  Opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 halted,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   retire_s;
  logic [CNT_WIDTH-1:0]   instr_count_r;

  // An instruction retires in its final state; a store waits for mem_ready
  assign retire_s = is_final_state(state_r) ||
                    ((state_r == S_MEM_WRITE) && mem_ready);

  // TRAP is absorbing, so halted is sticky until rst
  assign halted      = (state_r == S_TRAP);
  assign busy        = (state_r != S_IDLE) && (state_r != S_TRAP);
  assign instr_count = instr_count_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_r <= {CNT_WIDTH{1'b0}};
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  // Next-state logic; run is only looked at in IDLE and on retire
  always_comb begin
    next_state_s = state_r;
    if (retire_s) begin
      next_state_s = run ? S_FETCH : S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:      next_state_s = run ? S_FETCH : S_IDLE;
        S_FETCH:     next_state_s = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
            OP_R:         next_state_s = S_EXECUTE;
            OP_BEQ:       next_state_s = S_BRANCH;
            OP_J:         next_state_s = S_JUMP;
            OP_ADDI:      next_state_s = S_ADDI_EX;
            default:      next_state_s = S_TRAP;
          endcase
        end
        // IR still holds the opcode, so it selects load vs store here
        S_MEM_ADDR:  next_state_s = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  next_state_s = mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WRITE: next_state_s = S_MEM_WRITE;
        S_EXECUTE:   next_state_s = S_R_WB;
        S_ADDI_EX:   next_state_s = S_ADDI_WB;
        S_TRAP:      next_state_s = S_TRAP;
        default:     next_state_s = S_IDLE;
      endcase
    end
  end

  // Output decode; everything defaults low so IDLE and TRAP drive nothing
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:    ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller.
// The driver picks inputs each cycle, advances an instruction-level model
// (a queue of remaining phases per instruction) and pushes the expected
// outputs; the monitor pops and compares on the falling edge.
// A narrow counter is used so wrap-around is exercised.
module tb_multicycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [5:0]    Opcode = 6'd0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic          halted, busy;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.OP_WIDTH(6), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .halted(halted), .busy(busy),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Instruction phases as seen from the instruction's point of view
  typedef enum int {PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW,
                    PH_EX, PH_RWB, PH_BR, PH_J, PH_AEX, PH_AWB} phase_t;

  typedef struct {
    logic [15:0]   ctrl;
    logic          busy;
    logic          halted;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  bit   drive_done = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  // Control vector packing:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  function automatic logic [15:0] phase_ctrl(input phase_t ph, input logic mr);
    logic [15:0] c;
    case (ph)
      PH_F:    c = mr ? 16'h9410 : 16'h1010;
      PH_D:    c = 16'h0030;
      PH_MA:   c = 16'h0060;
      PH_MR:   c = 16'h3000;
      PH_MWB:  c = 16'h0280;
      PH_MW:   c = 16'h2800;
      PH_EX:   c = 16'h0048;
      PH_RWB:  c = 16'h0180;
      PH_BR:   c = 16'h4045;
      PH_J:    c = 16'h8002;
      PH_AEX:  c = 16'h0060;
      PH_AWB:  c = 16'h0080;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] pick_opcode();
    logic [5:0] legal [6];
    legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
    legal[3] = 6'b000100; legal[4] = 6'b000010; legal[5] = 6'b001000;
    if ($urandom_range(0, 99) < 90) return legal[$urandom_range(0, 5)];
    return 6'($urandom_range(0, 63));
  endfunction

  // Driver and reference model
  initial begin : driver
    phase_t    plan[$];
    phase_t    ph;
    int        cnt_m;
    bit        hlt_m;
    exp_t      e;
    cnt_m = 0;
    hlt_m = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 3) rst = 1'b1;
      else         rst = ($urandom_range(0, 59) == 0);
      run       = (cyc < 6) ? 1'b0 : ($urandom_range(0, 9) != 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      if (plan.size() == 0 || plan[0] == PH_F) Opcode = pick_opcode();

      e.ctrl = 16'h0000; e.busy = 1'b0; e.halted = 1'b0; e.count = CW'(cnt_m);
      if (rst) begin
        plan.delete();
        cnt_m = 0;
        hlt_m = 1'b0;
        e.count = '0;
      end else if (hlt_m) begin
        e.halted = 1'b1;
      end else if (plan.size() == 0) begin
        if (run) plan.push_back(PH_F);
      end else begin
        ph = plan[0];
        e.ctrl = phase_ctrl(ph, mem_ready);
        e.busy = 1'b1;
        if (!((ph == PH_F || ph == PH_MR || ph == PH_MW) && !mem_ready)) begin
          void'(plan.pop_front());
          if (ph == PH_F) begin
            plan.push_back(PH_D);
          end else if (ph == PH_D) begin
            case (Opcode)
              6'b000000: begin plan.push_back(PH_EX); plan.push_back(PH_RWB); end
              6'b100011: begin plan.push_back(PH_MA); plan.push_back(PH_MR); plan.push_back(PH_MWB); end
              6'b101011: begin plan.push_back(PH_MA); plan.push_back(PH_MW); end
              6'b000100: plan.push_back(PH_BR);
              6'b000010: plan.push_back(PH_J);
              6'b001000: begin plan.push_back(PH_AEX); plan.push_back(PH_AWB); end
              default:   hlt_m = 1'b1;
            endcase
          end else if (plan.size() == 0) begin
            cnt_m = (cnt_m + 1) % (1 << CW);
            if (run) plan.push_back(PH_F);
          end
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(posedge clk);
    drive_done = 1'b1;
  end

  // Monitor: compare each expected entry with the DUT mid-cycle
  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        n_checks += 4;
        if (act !== e.ctrl) begin
          n_fails++;
          $display("FAIL ctrl t=%0t got=%h want=%h", $time, act, e.ctrl);
        end
        if (busy !== e.busy) begin
          n_fails++;
          $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
        end
        if (halted !== e.halted) begin
          n_fails++;
          $display("FAIL halted t=%0t got=%b want=%b", $time, halted, e.halted);
        end
        if (instr_count !== e.count) begin
          n_fails++;
          $display("FAIL count t=%0t got=%0d want=%0d", $time, instr_count, e.count);
        end
      end else if (drive_done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    end
  end

endmodule
